// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, requests imem, holds the returned word for decode; drops stale responses after redirects.
// Latency: 2 cycles/instr minimum (REQ with same-cycle rvalid, then HOLD). Backpressure: HOLD waits on i_if_clk_en.
// Optional misaligned-redirect pulse under macro IF_MISALIGN_CHK_EN (default build: target[1:0] forced to 0, no pulse).
module instr_fetch_unit #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int              TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_if_clk_en,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_instr_ready,
    output logic [XLEN-1:0] o_if_pc,
    output logic [31:0]     o_if_instr,
    output logic            o_if_valid,
    output logic            o_fetch_timeout,
    output logic            o_fetch_misaligned
);

    localparam logic [31:0]     NOP_INSTR   = 32'h0000_0013;
    localparam logic [15:0]     TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~{{(XLEN-2){1'b0}}, 2'b11};
    localparam logic [XLEN-1:0] PC_STEP     = {{(XLEN-3){1'b0}}, 3'd4};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr_buf;
    logic            drop;
    logic [15:0]     wait_cnt;
    logic            timeout_q;

    logic [XLEN-1:0] redirect_pc;
    logic            in_req;
    logic            rsp_accept;
    logic            advance;
    logic            enter_req;
    logic            req_wait;
    logic [15:0]     wait_cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = REQ;
            REQ:     if (i_imem_rvalid && !drop) state_nxt = HOLD;
            HOLD:    if (i_if_clk_en) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
        // A redirect restarts the fetch from any state.
        if (i_branch_taken) begin
            state_nxt = REQ;
        end
    end

    always_comb begin
        redirect_pc  = i_branch_target & ALIGN_MASK;
        in_req       = (state == REQ);
        rsp_accept   = in_req && i_imem_rvalid && !drop && !i_branch_taken;
        advance      = (state == HOLD) && i_if_clk_en && !i_branch_taken;
        enter_req    = i_branch_taken || ((state != REQ) && (state_nxt == REQ));
        req_wait     = in_req && !i_imem_rvalid && !i_branch_taken;
        wait_cnt_inc = wait_cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            instr_buf <= NOP_INSTR;
        end else begin
            if (i_branch_taken) begin
                pc <= redirect_pc;
            end else if (advance) begin
                pc <= pc + PC_STEP;
            end
            if (rsp_accept) begin
                instr_buf <= i_imem_rdata;
            end
        end
    end

    // drop marks one in-flight response that belongs to an abandoned PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop <= 1'b0;
        end else if (i_branch_taken) begin
            if (in_req && !i_imem_rvalid) begin
                drop <= 1'b1;
            end
        end else if (in_req && i_imem_rvalid && drop) begin
            drop <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            if (enter_req) begin
                wait_cnt <= 16'd0;
            end else if (req_wait && (wait_cnt != TIMEOUT_VAL)) begin
                wait_cnt <= wait_cnt_inc;
                if (wait_cnt_inc == TIMEOUT_VAL) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    logic misaligned_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= i_branch_taken && (i_branch_target[1:0] != 2'b00);
        end
    end

    assign o_fetch_misaligned = misaligned_q;
`else
    assign o_fetch_misaligned = 1'b0;
`endif

    assign o_imem_req      = in_req;
    assign o_imem_addr     = pc;
    assign o_instr_ready   = (state == HOLD);
    assign o_if_valid      = (state == HOLD);
    assign o_if_pc         = pc;
    assign o_if_instr      = instr_buf;
    assign o_fetch_timeout = timeout_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a transaction-level PC/memory model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int TMO = 4;
`ifdef IF_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_if_clk_en = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic [31:0] i_branch_target = '0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_instr_ready;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_instr;
    logic        o_if_valid;
    logic        o_fetch_timeout;
    logic        o_fetch_misaligned;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_if_clk_en(i_if_clk_en),
        .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_instr_ready(o_instr_ready), .o_if_pc(o_if_pc), .o_if_instr(o_if_instr),
        .o_if_valid(o_if_valid), .o_fetch_timeout(o_fetch_timeout),
        .o_fetch_misaligned(o_fetch_misaligned)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Memory responder: one outstanding request, fixed or random latency (0 = same-cycle rvalid).
    bit          mem_en   = 1'b0;
    bit          mem_rand = 1'b0;
    int          mem_lat  = 0;
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic mem_drive();
        int lat;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = $urandom;
        if (rst) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = mem_word(mem_addr);
                mem_busy      = 1'b0;
            end
        end else if (mem_en && o_imem_req) begin
            mem_addr = o_imem_addr;
            lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
            if (lat == 0) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = mem_word(mem_addr);
            end else begin
                mem_busy = 1'b1;
                mem_cnt  = lat;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mem_drive();
    endtask

    // Leaves the DUT in IDLE at a falling edge with reset just released.
    task automatic do_reset();
        rst = 1'b1;
        i_branch_taken = 1'b0;
        i_branch_target = '0;
        i_if_clk_en = 1'b0;
        i_imem_rvalid = 1'b0;
        mem_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_if_clk_en = 1'b1;
        mem_en = 1'b0;
        @(negedge clk);
        n_checks++; if (o_imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", o_imem_req); else n_pass++;
        n_checks++; if (o_imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", o_imem_addr); else n_pass++;
        n_checks++; if (o_if_pc !== 32'h0) $display("FAIL rst_if_pc got %h exp 0", o_if_pc); else n_pass++;
        n_checks++; if (o_if_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", o_if_valid); else n_pass++;
        n_checks++; if (o_instr_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", o_instr_ready); else n_pass++;
        n_checks++; if (o_fetch_timeout !== 1'b0) $display("FAIL rst_timeout got %b exp 0", o_fetch_timeout); else n_pass++;
        n_checks++; if (o_fetch_misaligned !== 1'b0) $display("FAIL rst_misaligned got %b exp 0", o_fetch_misaligned); else n_pass++;
        rst = 1'b0;
        n_checks++; if (o_imem_req !== 1'b0) $display("FAIL idle_req got %b exp 0", o_imem_req); else n_pass++;
        tick();
        n_checks++; if (o_imem_req !== 1'b1) $display("FAIL first_req got %b exp 1", o_imem_req); else n_pass++;
        n_checks++; if (o_imem_addr !== 32'h0) $display("FAIL first_addr got %h exp 0", o_imem_addr); else n_pass++;
    endtask

    task automatic test_sequential();
        do_reset();
        mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 0;
        i_if_clk_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (o_imem_req !== 1'b1 || o_if_valid !== 1'b0) $display("FAIL seq_req k=%0d got req=%b valid=%b exp req=1 valid=0", k, o_imem_req, o_if_valid); else n_pass++;
            n_checks++; if (o_imem_addr !== 32'(4 * k)) $display("FAIL seq_addr k=%0d got %h exp %h", k, o_imem_addr, 32'(4 * k)); else n_pass++;
            tick();
            n_checks++; if (o_if_valid !== 1'b1 || o_imem_req !== 1'b0) $display("FAIL seq_valid k=%0d got valid=%b req=%b exp valid=1 req=0", k, o_if_valid, o_imem_req); else n_pass++;
            n_checks++; if (o_if_pc !== 32'(4 * k)) $display("FAIL seq_pc k=%0d got %h exp %h", k, o_if_pc, 32'(4 * k)); else n_pass++;
            n_checks++; if (o_if_instr !== mem_word(32'(4 * k))) $display("FAIL seq_instr k=%0d got %h exp %h", k, o_if_instr, mem_word(32'(4 * k))); else n_pass++;
        end
        i_if_clk_en = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 0;
        i_if_clk_en = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (o_if_valid !== 1'b1 || o_imem_req !== 1'b0) $display("FAIL stall_state c=%0d got valid=%b req=%b exp valid=1 req=0", c, o_if_valid, o_imem_req); else n_pass++;
            n_checks++; if (o_if_pc !== 32'h0 || o_if_instr !== mem_word(32'h0)) $display("FAIL stall_hold c=%0d got pc=%h instr=%h exp pc=0 instr=%h", c, o_if_pc, o_if_instr, mem_word(32'h0)); else n_pass++;
            tick();
        end
        i_if_clk_en = 1'b1;
        tick();
        i_if_clk_en = 1'b0;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) $display("FAIL stall_release got req=%b addr=%h exp req=1 addr=4", o_imem_req, o_imem_addr); else n_pass++;
    endtask

    task automatic test_redirect_pending();
        bit ok;
        do_reset();
        mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 2;
        i_if_clk_en = 1'b1;
        tick();
        i_branch_taken = 1'b1; i_branch_target = 32'h100;
        tick();
        i_branch_taken = 1'b0;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) $display("FAIL redir_addr got req=%b addr=%h exp req=1 addr=100", o_imem_req, o_imem_addr); else n_pass++;
        tick();
        tick();
        n_checks++; if (o_if_valid !== 1'b0 || o_imem_req !== 1'b1) $display("FAIL redir_drop got valid=%b req=%b exp valid=0 req=1", o_if_valid, o_imem_req); else n_pass++;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            tick();
            if (o_if_valid) ok = 1'b1;
        end
        n_checks++; if (ok !== 1'b1) $display("FAIL redir_wait got no valid exp valid within 10 cycles"); else n_pass++;
        n_checks++; if (o_if_pc !== 32'h100) $display("FAIL redir_pc got %h exp 100", o_if_pc); else n_pass++;
        n_checks++; if (o_if_instr !== mem_word(32'h100)) $display("FAIL redir_instr got %h exp %h", o_if_instr, mem_word(32'h100)); else n_pass++;
        i_if_clk_en = 1'b0;
    endtask

    task automatic test_redirect_hold();
        do_reset();
        mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 0;
        i_if_clk_en = 1'b0;
        i_branch_taken = 1'b1; i_branch_target = 32'h20;
        tick();
        i_branch_taken = 1'b0;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h20) $display("FAIL idle_redir got req=%b addr=%h exp req=1 addr=20", o_imem_req, o_imem_addr); else n_pass++;
        tick();
        n_checks++; if (o_if_valid !== 1'b1 || o_if_pc !== 32'h20) $display("FAIL hold20 got valid=%b pc=%h exp valid=1 pc=20", o_if_valid, o_if_pc); else n_pass++;
        i_if_clk_en = 1'b1; i_branch_taken = 1'b1; i_branch_target = 32'h40;
        tick();
        i_if_clk_en = 1'b0; i_branch_taken = 1'b0;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h40) $display("FAIL redir_prio got req=%b addr=%h exp req=1 addr=40", o_imem_req, o_imem_addr); else n_pass++;
        tick();
        n_checks++; if (o_if_pc !== 32'h40 || o_if_instr !== mem_word(32'h40)) $display("FAIL hold40 got pc=%h instr=%h exp pc=40 instr=%h", o_if_pc, o_if_instr, mem_word(32'h40)); else n_pass++;
        i_branch_taken = 1'b1; i_branch_target = 32'hFFFF_FFFC;
        tick();
        i_branch_taken = 1'b0;
        tick();
        n_checks++; if (o_if_valid !== 1'b1 || o_if_pc !== 32'hFFFF_FFFC) $display("FAIL top_pc got valid=%b pc=%h exp valid=1 pc=fffffffc", o_if_valid, o_if_pc); else n_pass++;
        i_if_clk_en = 1'b1;
        tick();
        i_if_clk_en = 1'b0;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) $display("FAIL wrap_addr got req=%b addr=%h exp req=1 addr=0", o_imem_req, o_imem_addr); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        mem_en = 1'b0; mem_rand = 1'b0; mem_lat = 0;
        i_if_clk_en = 1'b1;
        for (int c = 0; c < TMO; c++) begin
            tick();
            n_checks++; if (o_imem_req !== 1'b1 || o_fetch_timeout !== 1'b0) $display("FAIL tmo_early c=%0d got req=%b timeout=%b exp req=1 timeout=0", c, o_imem_req, o_fetch_timeout); else n_pass++;
        end
        mem_en = 1'b1;
        tick();
        n_checks++; if (o_fetch_timeout !== 1'b1) $display("FAIL tmo_set got %b exp 1", o_fetch_timeout); else n_pass++;
        mem_en = 1'b0;
        tick();
        n_checks++; if (o_if_valid !== 1'b1 || o_fetch_timeout !== 1'b1) $display("FAIL tmo_sticky got valid=%b timeout=%b exp valid=1 timeout=1", o_if_valid, o_fetch_timeout); else n_pass++;
        tick();
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) $display("FAIL tmo_next got req=%b addr=%h exp req=1 addr=4", o_imem_req, o_imem_addr); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (o_imem_req !== 1'b0 || o_if_valid !== 1'b0 || o_instr_ready !== 1'b0) $display("FAIL midrst_ctl got req=%b valid=%b ready=%b exp 0 0 0", o_imem_req, o_if_valid, o_instr_ready); else n_pass++;
        n_checks++; if (o_imem_addr !== 32'h0 || o_if_pc !== 32'h0) $display("FAIL midrst_pc got addr=%h pc=%h exp 0 0", o_imem_addr, o_if_pc); else n_pass++;
        n_checks++; if (o_fetch_timeout !== 1'b0 || o_fetch_misaligned !== 1'b0) $display("FAIL midrst_flags got timeout=%b mis=%b exp 0 0", o_fetch_timeout, o_fetch_misaligned); else n_pass++;
        i_if_clk_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_misalign();
        do_reset();
        mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 0;
        i_if_clk_en = 1'b0;
        i_branch_taken = 1'b1; i_branch_target = 32'h103;
        tick();
        i_branch_taken = 1'b0;
        n_checks++; if (o_imem_addr !== 32'h100) $display("FAIL mis_addr got %h exp 100", o_imem_addr); else n_pass++;
        n_checks++; if (o_fetch_misaligned !== MIS_EN) $display("FAIL mis_pulse got %b exp %b", o_fetch_misaligned, MIS_EN); else n_pass++;
        tick();
        n_checks++; if (o_fetch_misaligned !== 1'b0) $display("FAIL mis_clear got %b exp 0", o_fetch_misaligned); else n_pass++;
        n_checks++; if (o_if_pc !== 32'h100 || o_if_instr !== mem_word(32'h100)) $display("FAIL mis_fetch got pc=%h instr=%h exp pc=100 instr=%h", o_if_pc, o_if_instr, mem_word(32'h100)); else n_pass++;
        i_branch_taken = 1'b1; i_branch_target = 32'h200;
        tick();
        i_branch_taken = 1'b0;
        n_checks++; if (o_fetch_misaligned !== 1'b0 || o_imem_addr !== 32'h200) $display("FAIL mis_aligned got mis=%b addr=%h exp mis=0 addr=200", o_fetch_misaligned, o_imem_addr); else n_pass++;
    endtask

    // Transaction-level model: the PC advances by 4 per accepted instruction, jumps to the aligned
    // target on a redirect, and every presented instruction must be memory's word for that PC.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        bit          exp_mis;
        bit          br;
        bit          en;
        int          n_instr;
        do_reset();
        mem_en = 1'b1; mem_rand = 1'b1;
        exp_pc = 32'h0; exp_mis = 1'b0; n_instr = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            n_checks++; if (o_imem_addr !== exp_pc || o_if_pc !== exp_pc) $display("FAIL rnd_pc c=%0d got addr=%h pc=%h exp %h", c, o_imem_addr, o_if_pc, exp_pc); else n_pass++;
            n_checks++; if (o_fetch_misaligned !== exp_mis) $display("FAIL rnd_mis c=%0d got %b exp %b", c, o_fetch_misaligned, exp_mis); else n_pass++;
            n_checks++; if (o_instr_ready !== o_if_valid || (o_imem_req && o_if_valid)) $display("FAIL rnd_ctl c=%0d got req=%b valid=%b ready=%b exp ready=valid and not req&valid", c, o_imem_req, o_if_valid, o_instr_ready); else n_pass++;
            if (o_if_valid) begin
                n_checks++; if (o_if_instr !== mem_word(exp_pc)) $display("FAIL rnd_instr c=%0d got %h exp %h", c, o_if_instr, mem_word(exp_pc)); else n_pass++;
            end
            br  = ($urandom_range(0, 15) == 0);
            en  = 1'($urandom_range(0, 1));
            tgt = $urandom;
            i_branch_taken  = br;
            i_branch_target = tgt;
            i_if_clk_en     = en;
            if (o_if_valid && en && !br) n_instr++;
            exp_mis = MIS_EN && br && (tgt[1:0] != 2'b00);
            if (br) exp_pc = tgt & 32'hFFFF_FFFC;
            else if (o_if_valid && en) exp_pc = exp_pc + 32'd4;
        end
        i_branch_taken = 1'b0;
        i_if_clk_en = 1'b0;
        n_checks++; if (n_instr < 100) $display("FAIL rnd_progress got %0d instrs exp >= 100", n_instr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_pending();
        test_redirect_hold();
        test_timeout();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch (IF) stage. Owns the program counter, issues requests to instruction memory and holds the returned word for the decode stage. Drives `o_instr_ready` into the hazard controller and advances only when the controller's IF clock enable is high. Accepts branch/jump redirects from the execute stage and discards stale memory responses.

Parameters:
- XLEN, 32, address/PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT_CYCLES, 255, REQ-state wait cycles before the timeout flag sets (1..65535)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_if_clk_en  in  1  IF advance enable from hazard control
- i_branch_taken  in  1  redirect request from EX
- i_branch_target  in  XLEN  redirect address
- o_imem_req  out  1  instruction memory request
- o_imem_addr  out  XLEN  request address (equals PC)
- i_imem_rvalid  in  1  read data valid, one pulse per request
- i_imem_rdata  in  32  instruction word
- o_instr_ready  out  1  fetched word valid for current PC (to hazard control)
- o_if_pc  out  XLEN  PC of held instruction
- o_if_instr  out  32  held instruction
- o_if_valid  out  1  o_if_pc/o_if_instr valid for decode
- o_fetch_timeout  out  1  sticky memory-timeout flag
- o_fetch_misaligned  out  1  misaligned-redirect pulse (optional feature)

Behaviour:
- Reset (async, any state):
  - state=IDLE, pc=RESET_PC, instr buffer=32'h0000_0013 (NOP).
  - drop flag=0, wait counter=0.
  - All outputs 0, except o_imem_addr=RESET_PC and o_if_pc=RESET_PC.
- States IDLE, REQ, HOLD:
  - IDLE: one cycle after reset release, then go to REQ.
  - REQ:
    - o_imem_req=1, o_imem_addr=pc, held stable until a response or redirect.
    - On i_imem_rvalid with drop=0: buffer<=i_imem_rdata, go to HOLD.
    - On i_imem_rvalid with drop=1: discard the data, clear drop, remain in REQ.
  - HOLD:
    - o_instr_ready=1, o_if_valid=1, o_imem_req=0.
    - i_if_clk_en=1: pc<=pc+4 (mod 2^XLEN, wraps to 0), go to REQ.
    - i_if_clk_en=0: pc, buffer and state all hold.
- o_instr_ready = o_if_valid = (state==HOLD). o_if_pc=pc; o_if_instr=buffer.
- Minimum throughput: 2 cycles per instruction (one REQ cycle with same-cycle rvalid, then HOLD).
- Redirect (i_branch_taken=1) has priority over everything except reset:
  - pc<=i_branch_target, state<=REQ, wait counter<=0.
  - In REQ without same-cycle rvalid, the old request is outstanding: drop<=1.
  - In REQ with same-cycle rvalid: that data is discarded, drop stays 0.
  - In HOLD: redirect wins over i_if_clk_en.
  - In IDLE: go directly to REQ at the target.
- Redirect while drop=1: drop stays 1. Exactly one response is still owed.
- Wait counter:
  - Cleared on entry to REQ.
  - Increments each REQ cycle without rvalid; saturates.
  - When the counter reaches TIMEOUT_CYCLES, o_fetch_timeout<=1 (sticky until reset). Fetch keeps waiting.
- i_if_clk_en is ignored outside HOLD.
- i_imem_rvalid is ignored in IDLE and HOLD.

Optional Feature:
Macro IF_MISALIGN_CHK_EN.
- Defined: a redirect with target[1:0]!=0 loads pc={target[XLEN-1:2],2'b00} and pulses o_fetch_misaligned high for exactly the cycle after the redirect.
- Undefined: target[1:0] is silently forced to 0 and o_fetch_misaligned is tied 0.

Test Plan:
1. Reset, then memory returning rvalid in the same cycle as req with i_if_clk_en=1 -> addresses 0x0, 0x4, 0x8; o_if_valid every 2nd cycle; o_if_instr matches rdata.
2. Hold i_if_clk_en=0 in HOLD for 5 cycles -> o_if_pc/o_if_instr stable, o_imem_req=0; release -> next address is pc+4.
3. Redirect to 0x100 during REQ with response pending, old rvalid 2 cycles later -> old data dropped, o_imem_addr=0x100, o_if_pc=0x100 after its rvalid.
4. Simultaneous i_branch_taken (target 0x40) and i_if_clk_en in HOLD at pc 0x20 -> next request address 0x40, not 0x24.
5. With TIMEOUT_CYCLES=4, withhold rvalid -> o_fetch_timeout=1 after 4 REQ cycles and stays 1 after a later rvalid; assert rst mid-REQ -> all outputs at reset values, pc=RESET_PC.
6. With IF_MISALIGN_CHK_EN, redirect to 0x103 -> o_imem_addr=0x100, o_fetch_misaligned one-cycle pulse; without the macro -> no pulse.
